// File: rtl/spi_master_feeder_if.sv
// Master-side link between the byte feeder and the SPI core.
// The master modport is the feeder side. It drives the byte and the start pulse.
// The slave modport is the core side. It returns the done strobes and the received byte.
interface spi_master_feeder_if;
  logic [7:0] master_data_in;
  logic       tx_start;
  logic       master_tx_done;
  logic       master_rx_done;
  logic [7:0] master_data_out;

  modport master (
    output master_data_in,
    output tx_start,
    input  master_tx_done,
    input  master_rx_done,
    input  master_data_out
  );

  modport slave (
    input  master_data_in,
    input  tx_start,
    output master_tx_done,
    output master_rx_done,
    output master_data_out
  );
endinterface

// File: rtl/spi_master_feeder.sv
// spi_master_feeder: TX byte FIFO in front of the SPI master. It launches one byte
// at a time and returns each received byte on a valid/ready port.
// Optional macro SPI_FEEDER_GAP_EN adds a GAP state that inserts GAP_CYCLES idle
// clocks after every transfer.
module spi_master_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  spi_master_feeder_if.master    spi,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Reject bad parameter values at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_master_feeder: DEPTH must be a power of two and >= 2");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("spi_master_feeder: GAP_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
`ifdef SPI_FEEDER_GAP_EN
    , S_GAP  = 2'd3
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [7:0]      r_mdata;
  logic            r_ovf;
  logic            r_tx_seen;
  logic            r_rx_seen;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            w_wr_acc;
  logic            w_pop;
  logic            w_tx_any;
  logic            w_rx_any;
  logic            w_done_both;
  logic            w_rx_cap;
`ifdef SPI_FEEDER_GAP_EN
  logic [7:0]      r_gap_cnt;
`endif

  assign full        = (r_level == LW'(DEPTH));
  assign empty       = (r_level == '0);
  assign level       = r_level;
  assign overflow    = r_ovf;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state != S_IDLE) || !empty;

  assign spi.master_data_in = r_mdata;
  assign spi.tx_start       = (r_state == S_LAUNCH);

  // A pop happens only from IDLE, and only when the previous rx byte has been taken.
  assign w_wr_acc    = wr_en && !full;
  assign w_pop       = (r_state == S_IDLE) && !empty && !r_rx_valid;
  assign w_tx_any    = r_tx_seen | spi.master_tx_done;
  assign w_rx_any    = r_rx_seen | spi.master_rx_done;
  assign w_done_both = (r_state == S_WAIT) && w_tx_any && w_rx_any;
  assign w_rx_cap    = (r_state == S_WAIT) && spi.master_rx_done && !r_rx_seen;

  // FIFO storage. It has no reset and is written only by accepted pushes.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wr_data;
  end

  // Pointers, occupancy and the registered head byte for the master.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_mdata <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_mdata <= r_mem[r_rptr];
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag. A dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_ovf <= 1'b0;
    else if (wr_en && full) r_ovf <= 1'b1;
    else if (ovf_clr)       r_ovf <= 1'b0;
  end

  // Done-strobe latches. They count only in WAIT and clear when WAIT exits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_seen <= 1'b0;
      r_rx_seen <= 1'b0;
    end else if (r_state != S_WAIT || w_done_both) begin
      r_tx_seen <= 1'b0;
      r_rx_seen <= 1'b0;
    end else begin
      if (spi.master_tx_done) r_tx_seen <= 1'b1;
      if (spi.master_rx_done) r_rx_seen <= 1'b1;
    end
  end

  // Received byte holding register with its valid/ready handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_cap) begin
      r_rx_data  <= spi.master_data_out;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_FEEDER_GAP_EN
  // Inter-byte gap counter. It restarts from zero each time GAP is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_gap_cnt <= '0;
    else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt + 1'b1;
    else                        r_gap_cnt <= '0;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_next = S_LAUNCH;
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_done_both) begin
`ifdef SPI_FEEDER_GAP_EN
          w_state_next = S_GAP;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef SPI_FEEDER_GAP_EN
      S_GAP:    if (r_gap_cnt == 8'(GAP_CYCLES - 1)) w_state_next = S_IDLE;
`endif
      default:  w_state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_feeder.sv
// Directed bench for spi_master_feeder. A small SPI-core model returns both done
// strobes a set number of cycles after each tx_start.
module tb_spi_master_feeder;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
`ifdef SPI_FEEDER_GAP_EN
  localparam int SPACING = 22 + GAP;
`else
  localparam int SPACING = 23;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       rx_ready = 1'b1;
  logic       full, empty, overflow, rx_valid, busy;
  logic [3:0] level;
  logic [7:0] rx_data;

  spi_master_feeder_if spi();

  spi_master_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .spi(spi), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  int         dtx = 20;
  int         drx = 20;
  logic [7:0] rx_byte = 8'hB7;
  bit         m_active = 1'b0;
  int         m_cnt = 0;
  bit         stray_tx = 1'b0;
  bit         stray_rx = 1'b0;
  logic [7:0] tx_log[$];
  int         tx_time[$];
  logic [7:0] rx_log[$];

  // SPI core model. It drives inputs 1 time unit after each falling edge.
  initial begin
    spi.master_tx_done  = 1'b0;
    spi.master_rx_done  = 1'b0;
    spi.master_data_out = 8'h00;
    forever begin
      @(negedge clk); #1;
      spi.master_tx_done = stray_tx;
      spi.master_rx_done = stray_rx;
      if (!reset_n) begin
        m_active = 1'b0;
      end else begin
        if (m_active) begin
          m_cnt++;
          if (m_cnt == dtx) spi.master_tx_done = 1'b1;
          if (m_cnt == drx) begin
            spi.master_rx_done  = 1'b1;
            spi.master_data_out = rx_byte;
          end
          if (m_cnt >= dtx && m_cnt >= drx) m_active = 1'b0;
        end
        if (spi.tx_start) begin
          tx_log.push_back(spi.master_data_in);
          tx_time.push_back(cyc);
          $display("tx_start byte=0x%02h cyc=%0d", spi.master_data_in, cyc);
          m_active = 1'b1;
          m_cnt    = 0;
        end
      end
    end
  end

  // Receive-side monitor. It records every accepted rx byte.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rx_valid && rx_ready) begin
        rx_log.push_back(rx_data);
        $display("rx accept byte=0x%02h cyc=%0d", rx_data, cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Call this task right at a falling edge. The byte is accepted on the next rising edge.
  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || rx_valid || m_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {26'd0, full, empty, overflow, spi.tx_start, rx_valid, busy}, 32'b010000);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_mdi"},   32'(spi.master_data_in), 32'h00);
    check({tag, "_rxd"},   32'(rx_data), 32'h00);
  endtask

  initial begin
    int b;
    int r;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // Single byte. Check the launch timing and the returned byte.
    wr(8'hAB);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    @(negedge clk);
    check("t1_start", 32'(spi.tx_start), 32'd1);
    check("t1_mdi",   32'(spi.master_data_in), 32'hAB);
    check("t1_level0", 32'(level), 32'd0);
    @(negedge clk);
    check("t1_pulse1", 32'(spi.tx_start), 32'd0);
    wait_idle("t1", 100);
    check("t1_ntx", 32'(tx_log.size()), 32'd1);
    check("t1_txb", 32'(tx_log[0]), 32'hAB);
    check("t1_nrx", 32'(rx_log.size()), 32'd1);
    check("t1_rxb", 32'(rx_log[0]), 32'hB7);
    check("t1_busy", 32'(busy), 32'd0);

    // Three bytes written back to back. Check the order and the exact launch spacing.
    b = tx_log.size();
    r = rx_log.size();
    wr(8'hE7); wr(8'h11); wr(8'h22);
    wait_idle("t2", 300);
    check("t2_ntx", 32'(tx_log.size() - b), 32'd3);
    check("t2_nrx", 32'(rx_log.size() - r), 32'd3);
    check("t2_b0", 32'(tx_log[b]),     32'hE7);
    check("t2_b1", 32'(tx_log[b + 1]), 32'h11);
    check("t2_b2", 32'(tx_log[b + 2]), 32'h22);
    check("t2_sp0", 32'(tx_time[b + 1] - tx_time[b]),     32'(SPACING));
    check("t2_sp1", 32'(tx_time[b + 2] - tx_time[b + 1]), 32'(SPACING));

    // Backpressure, then fill the FIFO, overflow it and clear the overflow flag.
    rx_byte  = 8'h3C;
    rx_ready = 1'b0;
    b = tx_log.size();
    wr(8'h01);
    n = 0;
    while (!rx_valid && n < 100) begin @(negedge clk); n++; end
    check("t3_rxv", 32'(rx_valid), 32'd1);
    check("t3_rxd", 32'(rx_data), 32'h3C);
    for (int i = 0; i < DEPTH; i++) wr(8'h80 + 8'(i));
    check("t3_level", 32'(level), 32'd8);
    check("t3_full",  32'(full), 32'd1);
    wr(8'h55);
    check("t3_ovf",   32'(overflow), 32'd1);
    check("t3_lvl8",  32'(level), 32'd8);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovfclr", 32'(overflow), 32'd0);
    repeat (20) @(negedge clk);
    check("t3_stall_ntx", 32'(tx_log.size() - b), 32'd1);
    check("t3_stall_rxv", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("t3_rel_rxv",   32'(rx_valid), 32'd0);
    check("t3_rel_start", 32'(spi.tx_start), 32'd0);
    @(negedge clk);
    check("t3_next_start", 32'(spi.tx_start), 32'd1);
    check("t3_next_mdi",   32'(spi.master_data_in), 32'h80);
    wait_idle("t3", 400);
    check("t3_ntx", 32'(tx_log.size() - b), 32'd9);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("t3_b%0d", i), 32'(tx_log[b + 1 + i]), 32'h80 + 32'(i));
    check("t3_empty", 32'(empty), 32'd1);

    // rx_done arrives 3 cycles before tx_done, then both arrive in the same cycle.
    b = tx_log.size();
    r = rx_log.size();
    dtx = 20; drx = 17;
    wr(8'hC3);
    wait_idle("t4a", 100);
    check("t4a_ntx", 32'(tx_log.size() - b), 32'd1);
    check("t4a_nrx", 32'(rx_log.size() - r), 32'd1);
    dtx = 10; drx = 10; rx_byte = 8'h5E;
    wr(8'h5A);
    wait_idle("t4b", 100);
    check("t4b_ntx", 32'(tx_log.size() - b), 32'd2);
    check("t4b_nrx", 32'(rx_log.size() - r), 32'd2);
    check("t4b_rxb", 32'(rx_log[r + 1]), 32'h5E);

    // Assert reset during WAIT with bytes still queued.
    dtx = 50; drx = 50;
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    repeat (10) @(negedge clk);
    check("t5_level_pre", 32'(level), 32'd2);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b = tx_log.size();
    r = rx_log.size();
    @(negedge clk);
    stray_tx = 1'b1; stray_rx = 1'b1;
    @(negedge clk);
    stray_tx = 1'b0; stray_rx = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_ntx", 32'(tx_log.size() - b), 32'd0);
    check("t5_nrx", 32'(rx_log.size() - r), 32'd0);
    check_reset_outputs("t5_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_master_feeder.md
# spi_master_feeder

Byte-queue front end for the SPI master. Software-side logic pushes bytes into an internal TX FIFO; the feeder pops them one at a time, presents each on the master's `master_data_in`, pulses `tx_start`, waits for the master's completion strobes, and returns each received byte on a valid/ready port. It sits directly upstream of the SPI core's master-side inputs and consumes the core's master-side done and data outputs.

## Interface
- `DEPTH`, 8: TX FIFO depth in bytes; must be a power of two and ≥2.
- `GAP_CYCLES`, 4: idle clocks between transfers, used only when `SPI_FEEDER_GAP_EN` is defined; range 1–255.

- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `wr_data` into the TX FIFO.
- `wr_data` in 8: byte to queue.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set by a dropped write.
- `ovf_clr` in 1: clears `overflow`. Set has priority when set and clear occur in the same cycle.
- `master_data_in` out 8: byte driven to the SPI master.
- `tx_start` out 1: one-cycle start pulse to the SPI master.
- `master_tx_done` in 1: master transmit-complete strobe.
- `master_rx_done` in 1: master receive-complete strobe.
- `master_data_out` in 8: byte received by the master.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: `rx_data` is pending.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `busy` out 1: the state is not IDLE, or `empty`=0.

## Operation
- TX FIFO is circular with wrapping read/write pointers. `level` is registered.
- A write is accepted when `wr_en`=1 and `full`=0.
- A write with `full`=1 is dropped and sets `overflow`. This holds even if a pop occurs in the same cycle.
- A simultaneous accepted write and pop leaves `level` unchanged.
- FSM states: IDLE, LAUNCH, WAIT, and GAP (GAP exists only with the macro defined).
  - IDLE → LAUNCH when `empty`=0 and `rx_valid`=0. On this edge the head byte is popped and registered into `master_data_in`.
  - LAUNCH: `tx_start`=1 for exactly this one cycle. Always → WAIT.
  - WAIT: the feeder latches `tx_seen` on `master_tx_done` and `rx_seen` on `master_rx_done`.
    - On `master_rx_done`, `master_data_out` is captured into `rx_data` and `rx_valid` is set.
    - When both strobes have been seen (same cycle or any order), the FSM clears both latches and moves → GAP if the macro is defined, otherwise → IDLE.
  - GAP: counts `GAP_CYCLES` clocks, then → IDLE.
- `master_data_in` holds its value from LAUNCH until the next pop.
- Done strobes that arrive outside WAIT are ignored.
- `rx_valid` clears on any cycle with `rx_valid`=1 and `rx_ready`=1.
- While `rx_valid`=1, no new transfer launches. Backpressure stalls the queue; no received byte is ever lost.

## Timing
- Reset values: `full`=0, `empty`=1, `level`=0, `overflow`=0, `master_data_in`=0, `tx_start`=0, `rx_data`=0, `rx_valid`=0, `busy`=0; state IDLE; FIFO pointers 0.
- Write into an empty FIFO at edge k: `empty`=0 after k; pop at edge k+1; `tx_start` is high between edges k+1 and k+2.
- `master_rx_done` sampled at edge m: `rx_valid`=1 and `rx_data` are valid after m.
- Back-to-back without the macro: both dones complete at edge m → IDLE after m. If `rx_valid` is cleared at m, the next pop occurs at m+1. Otherwise the feeder waits for `rx_ready`.
- Reset asserted mid-transfer: all state and queued bytes are discarded immediately. Outputs go to their reset values asynchronously. The SPI core shares the same reset.

## Configuration
- `SPI_FEEDER_GAP_EN`
  - Defined: the GAP state is compiled in. At least `GAP_CYCLES` clocks separate the exit from WAIT and the next pop, giving the slave inter-byte recovery time.
  - Undefined: GAP logic and `GAP_CYCLES` are unused, and WAIT → IDLE directly.

## Test plan
- Reset, then write 0xAB, `rx_ready`=1, with a model that fires both dones 20 cycles after `tx_start` and returns 0xB7 → one `tx_start` pulse with `master_data_in`=0xAB; then `rx_data`=0xB7 and `rx_valid` pulses; `busy` returns to 0.
- Write 0xE7, 0x11, 0x22 back-to-back → three `tx_start` pulses in that order, each only after both dones of the previous byte. With the macro, the inter-pulse spacing exceeds the transfer time by ≥`GAP_CYCLES`.
- Fill `DEPTH`=8, then write 0x55 while `full`=1 → `level`=8, 0x55 is never transmitted, `overflow`=1; `ovf_clr` → 0.
- Hold `rx_ready`=0 with two bytes queued → after the first transfer `rx_valid` stays 1 and no second `tx_start` occurs. Raising `rx_ready` launches the second byte the cycle after `rx_valid` clears.
- `master_rx_done` 3 cycles before `master_tx_done`, and separately both in the same cycle → exactly one completion each; no duplicate `rx_valid` and no missed transition.
- Assert `reset_n`=0 during WAIT with 3 bytes queued → all outputs return to reset values, `empty`=1; a stray done strobe after release produces no response.
